// File: rtl/fetch_entry_fifo.sv
// Fetch-entry decoupling FIFO between the frontend and decode.
// First-word fall-through from registered storage. Enqueue is blocked after an
// excepting entry until the next flush, so no wrong-path entries follow it.
module fetch_entry_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64,
  parameter int unsigned BP_W  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [VLEN-1:0]           in_address_i,
  input  logic [31:0]               in_instruction_i,
  input  logic [BP_W-1:0]           in_bp_i,
  input  logic                      in_ex_valid_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [VLEN-1:0]           out_address_o,
  output logic [31:0]               out_instruction_o,
  output logic [BP_W-1:0]           out_bp_o,
  output logic                      out_ex_valid_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      ex_blocked_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [VLEN-1:0] address;
    logic [31:0]     instruction;
    logic [BP_W-1:0] bp;
    logic            ex_valid;
  } entry_t;

  typedef enum logic {
    OPEN    = 1'b0,
    BLOCKED = 1'b1
  } blk_state_e;

  entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  blk_state_e blk_q, blk_d;
  logic       ex_blk_q;
  logic       push, pop;
  entry_t     in_entry, head;

  assign ex_blk_q    = (blk_q == BLOCKED);

  // Handshake qualifiers; ready depends only on registered state.
  assign in_ready_o  = (count_q < CW'(DEPTH)) && !ex_blk_q;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign in_entry = '{address:     in_address_i,
                      instruction: in_instruction_i,
                      bp:          in_bp_i,
                      ex_valid:    in_ex_valid_i};

  // Head entry falls through from storage.
  assign head              = mem_q[rd_q];
  assign out_address_o     = head.address;
  assign out_instruction_o = head.instruction;
  assign out_bp_o          = head.bp;
  assign out_ex_valid_o    = head.ex_valid;
  assign count_o           = count_q;
  assign ex_blocked_o      = ex_blk_q;

  // Entry storage; cleared on reset so the data outputs never carry X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_q[wr_q] <= in_entry;
    end
  end

  // Pointers and occupancy; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Exception-block state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q <= OPEN;
    end else begin
      blk_q <= blk_d;
    end
  end

  // Exception-block next state: an excepting push closes, only flush reopens.
  always_comb begin
    blk_d = blk_q;
    if (flush_i) begin
      blk_d = OPEN;
    end else begin
      case (blk_q)
        OPEN:    if (push && in_ex_valid_i) blk_d = BLOCKED;
        BLOCKED: blk_d = BLOCKED;
        default: blk_d = OPEN;
      endcase
    end
  end

endmodule

// File: doc/fetch_entry_fifo.md
Name: fetch_entry_fifo

Overview:
Decoupling FIFO between the frontend and the instruction-decode stage. It buffers fetch entries (PC, raw 32-bit instruction, branch-prediction tag, fetch-exception flag) and presents them to decode through a valid/ready handshake, with first-word fall-through. On a fetch exception it stops accepting further entries until the next flush, so no wrong-path entries follow an excepting one. All entries are discarded on flush.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
VLEN, 64, width of the PC/address field
BP_W, 2, width of the opaque branch-prediction tag passed through unchanged

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  discard all entries and clear the exception block
in_valid_i  in  1  frontend presents an entry
in_ready_o  out  1  FIFO accepts the entry this cycle
in_address_i  in  VLEN  PC of the entry
in_instruction_i  in  32  raw instruction (compressed in [15:0])
in_bp_i  in  BP_W  branch-prediction tag
in_ex_valid_i  in  1  fetch exception attached to the entry
out_valid_o  out  1  head entry valid
out_ready_i  in  1  decode consumes the head
out_address_o  out  VLEN  head PC
out_instruction_o  out  32  head instruction
out_bp_o  out  BP_W  head tag
out_ex_valid_o  out  1  head exception flag
count_o  out  $clog2(DEPTH)+1  current occupancy
ex_blocked_o  out  1  enqueue blocked after an exception entry

Behaviour:
- Storage: circular buffer of DEPTH entries with read pointer rd_q and write pointer wr_q, each $clog2(DEPTH) bits and wrapping modulo DEPTH. Occupancy count_q ranges 0..DEPTH.
- Reset values: rd_q=0, wr_q=0, count_q=0, ex_blk_q=0. So out_valid_o=0, in_ready_o=1, count_o=0, ex_blocked_o=0. Storage contents are don't-care, but out_* data outputs must not be X-propagating into control logic.
- in_ready_o = (count_q < DEPTH) && !ex_blk_q. This is purely registered. There is no combinational path from out_ready_i to in_ready_o.
- push = in_valid_i && in_ready_o. pop = out_valid_o && out_ready_i.
- out_valid_o = (count_q != 0). out_* fields = mem[rd_q], combinational from registers (fall-through). Zero-cycle latency from a registered entry to the output; an entry written in cycle N is visible in cycle N+1.
- Push writes mem[wr_q] and increments wr_q. Pop increments rd_q. count_q += push - pop.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count_q == DEPTH, push is impossible because in_ready_o is 0, even if pop happens the same cycle.
- Pushing an empty FIFO never bypasses the storage: out_valid_o stays 0 in the push cycle.
- Exception block state machine, two states:
  - OPEN (ex_blk_q=0): a push with in_ex_valid_i=1 moves to BLOCKED at the next edge.
  - BLOCKED (ex_blk_q=1): in_ready_o=0. Entries already queued still drain normally. The only exit is flush_i, which returns to OPEN.
- ex_blocked_o = ex_blk_q.
- flush_i has the highest priority. At the next edge: rd_q=wr_q=0, count_q=0, ex_blk_q=0. Any push or pop in the flush cycle is ignored for state update, but in_ready_o/out_valid_o still show their pre-flush values during that cycle.
- Asynchronous reset mid-operation returns immediately to the reset values; in-flight entries are lost.
- Pointer wrap: when wr_q or rd_q is at DEPTH-1 and advances, it goes to 0.

Test Plan:
- Reset, then push 3 entries (PC 0x80000000/04/08, out_ready_i=0) -> count_o=3, out_address_o=0x80000000; then set out_ready_i=1 -> pops in order, out_valid_o=0 after the third.
- Fill to DEPTH=4 -> in_ready_o=0, count_o=4; hold in_valid_i=1 and pop once -> in_ready_o stays 0 in the pop cycle, returns to 1 the next cycle, and no entry is lost or duplicated.
- Continuous push and pop for 10 cycles starting with 1 entry queued -> count_o stays 1, pointers wrap past 3, PCs come out in order.
- Push an entry with in_ex_valid_i=1 at PC 0x100 followed by valid entries -> ex_blocked_o=1 the next cycle, in_ready_o=0, queue drains through 0x100 then out_valid_o=0; assert flush_i -> ex_blocked_o=0, in_ready_o=1.
- With 2 entries queued, assert flush_i together with push and pop -> next cycle count_o=0, out_valid_o=0, and the pushed entry is absent.
- Assert rst_ni low asynchronously mid-stream with 3 entries queued -> out_valid_o=0 and count_o=0 immediately, in_ready_o=1.
